// File: rtl/fsm_input_pkg.sv
// Shared definitions for the pet input front-end: ultrasonic state encoding
// and the default timing constants for simulation and FPGA builds.
package fsm_input_pkg;

    typedef enum logic [2:0] {
        US_IDLE      = 3'd0,
        US_TRIG      = 3'd1,
        US_WAIT_RISE = 3'd2,
        US_MEASURE   = 3'd3,
        US_DONE      = 3'd4,
        US_HOLDOFF   = 3'd5
    } us_state_t;

    localparam int DEF_CNT_W = 22;

    // Short timings so a simulation covers several ranging periods quickly
    localparam int TB_DEB_CYCLES    = 4;
    localparam int TB_TRIG_CYCLES   = 10;
    localparam int TB_PERIOD_CYCLES = 200;
    localparam int TB_NEAR_CYCLES   = 60;
    localparam int TB_ECHO_TIMEOUT  = 150;

    localparam int FPGA_DEB_CYCLES    = 500000;
    localparam int FPGA_TRIG_CYCLES   = 500;
    localparam int FPGA_PERIOD_CYCLES = 3000000;
    localparam int FPGA_NEAR_CYCLES   = 1500000;
    localparam int FPGA_ECHO_TIMEOUT  = 2000000;

endpackage

// File: rtl/fsm_input_frontend_debouncer.sv
// One input channel: 2-FF synchroniser, stability counter, debounced level
// and a single-cycle pulse on the debounced inactive->active edge.
module debouncer
    import fsm_input_pkg::*;
#(
    parameter int DEB_CYCLES = TB_DEB_CYCLES,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_pulse
);

    localparam logic IDLE_LVL = ACTIVE_LOW;
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic          r_level;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;
    logic          w_flip;

    // The counter only advances while the sample is steady and disagrees
    // with the debounced level; it never passes CNT_LAST.
    assign w_flip = (r_sync2 != r_level) && (r_sync2 == r_prev) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= IDLE_LVL;
            r_sync2 <= IDLE_LVL;
            r_prev  <= IDLE_LVL;
            r_level <= IDLE_LVL;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if ((r_sync2 == r_level) || (r_sync2 != r_prev) || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_flip) begin
                r_level <= r_sync2;
            end
            r_pulse <= w_flip && (r_sync2 != IDLE_LVL);
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/fsm_input_frontend.sv
// Input front-end for the pet state machine: debounced button/LDR event
// pulses and the HC-SR04 trigger/echo ranging FSM.
module fsm_input_frontend
    import fsm_input_pkg::*;
#(
    parameter int DEB_CYCLES    = TB_DEB_CYCLES,
    parameter int TRIG_CYCLES   = TB_TRIG_CYCLES,
    parameter int PERIOD_CYCLES = TB_PERIOD_CYCLES,
    parameter int NEAR_CYCLES   = TB_NEAR_CYCLES,
    parameter int ECHO_TIMEOUT  = TB_ECHO_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_feed_n,
    input  logic             btn_heal_n,
    input  logic             btn_mode_n,
    input  logic             btn_test_n,
    input  logic             ldr_dark,
    input  logic             us_echo,
    output logic             us_trig,
    output logic             feeding,
    output logic             healing,
    output logic             change_state,
    output logic             test,
    output logic             light_out,
    output logic             echo_sig,
    output logic [CNT_W-1:0] range_cnt,
    output logic             range_valid
);

    localparam int PW = $clog2(PERIOD_CYCLES + 1);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(ECHO_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TMO_VAL   = CNT_W'(ECHO_TIMEOUT);
    localparam logic [CNT_W-1:0] NEAR_VAL  = CNT_W'(NEAR_CYCLES);
    localparam logic [PW-1:0]    PERIOD_VAL = PW'(PERIOD_CYCLES);

    debouncer #(.DEB_CYCLES(DEB_CYCLES), .ACTIVE_LOW(1'b1)) u_deb_feed (
        .clk(clk), .rst(rst), .i_raw(btn_feed_n), .o_pulse(feeding));
    debouncer #(.DEB_CYCLES(DEB_CYCLES), .ACTIVE_LOW(1'b1)) u_deb_heal (
        .clk(clk), .rst(rst), .i_raw(btn_heal_n), .o_pulse(healing));
    debouncer #(.DEB_CYCLES(DEB_CYCLES), .ACTIVE_LOW(1'b1)) u_deb_mode (
        .clk(clk), .rst(rst), .i_raw(btn_mode_n), .o_pulse(change_state));
    debouncer #(.DEB_CYCLES(DEB_CYCLES), .ACTIVE_LOW(1'b1)) u_deb_test (
        .clk(clk), .rst(rst), .i_raw(btn_test_n), .o_pulse(test));
    debouncer #(.DEB_CYCLES(DEB_CYCLES), .ACTIVE_LOW(1'b0)) u_deb_ldr (
        .clk(clk), .rst(rst), .i_raw(ldr_dark), .o_pulse(light_out));

    logic             r_echo_s1;
    logic             r_echo_s2;
    logic             r_echo_s3;
    us_state_t        r_state;
    us_state_t        w_next;
    logic             r_armed;
    logic [CNT_W-1:0] r_phase;
    logic [CNT_W-1:0] w_phase_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [PW-1:0]    r_period;
    logic             r_trig;
    logic             r_near;
    logic [CNT_W-1:0] r_range_cnt;
    logic             r_range_valid;
    logic             r_echo_sig;
    logic             w_trig_start;
    logic             w_done_entry;
    logic             w_near_new;

    // WAIT_RISE watches s2 while MEASURE counts s3, one cycle later, so the
    // first high echo cycle is included and the count equals the echo width.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_echo_s1 <= 1'b0;
            r_echo_s2 <= 1'b0;
            r_echo_s3 <= 1'b0;
        end else begin
            r_echo_s1 <= us_echo;
            r_echo_s2 <= r_echo_s1;
            r_echo_s3 <= r_echo_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= US_IDLE;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_next;
            r_armed <= 1'b1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_phase_next = r_phase;
        w_count_next = r_count;
        case (r_state)
            US_IDLE: begin
                if (r_armed) begin
                    w_next       = US_TRIG;
                    w_phase_next = '0;
                end
            end
            US_TRIG: begin
                if (r_phase == TRIG_LAST) begin
                    w_next       = US_WAIT_RISE;
                    w_phase_next = '0;
                end else begin
                    w_phase_next = r_phase + CNT_W'(1);
                end
            end
            US_WAIT_RISE: begin
                if (r_echo_s2) begin
                    w_next       = US_MEASURE;
                    w_count_next = '0;
                end else if (r_phase == TMO_LAST) begin
                    w_next       = US_DONE;
                    w_count_next = TMO_VAL;
                end else begin
                    w_phase_next = r_phase + CNT_W'(1);
                end
            end
            US_MEASURE: begin
                if (!r_echo_s3) begin
                    w_next = US_DONE;
                end else if (r_count == TMO_LAST) begin
                    w_next       = US_DONE;
                    w_count_next = TMO_VAL;
                end else begin
                    w_count_next = r_count + CNT_W'(1);
                end
            end
            US_DONE: begin
                w_next = US_HOLDOFF;
            end
            US_HOLDOFF: begin
                if ((r_period >= PERIOD_VAL) && !r_echo_s3) begin
                    w_next       = US_TRIG;
                    w_phase_next = '0;
                end
            end
            default: begin
                w_next = US_IDLE;
            end
        endcase
    end

    assign w_trig_start = (w_next == US_TRIG) && (r_state != US_TRIG);
    assign w_done_entry = (w_next == US_DONE);
    assign w_near_new   = (w_count_next < NEAR_VAL);

    // Outputs are registered from the next state so they line up with r_state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase       <= '0;
            r_count       <= '0;
            r_period      <= '0;
            r_trig        <= 1'b0;
            r_near        <= 1'b0;
            r_range_cnt   <= '0;
            r_range_valid <= 1'b0;
            r_echo_sig    <= 1'b0;
        end else begin
            r_phase <= w_phase_next;
            r_count <= w_count_next;
            if (w_trig_start) begin
                r_period <= PW'(1);
            end else if (r_period != {PW{1'b1}}) begin
                r_period <= r_period + PW'(1);
            end
            r_trig        <= (w_next == US_TRIG);
            r_range_valid <= w_done_entry;
            r_echo_sig    <= w_done_entry && w_near_new && !r_near;
            if (w_done_entry) begin
                r_range_cnt <= w_count_next;
                r_near      <= w_near_new;
            end
        end
    end

    assign us_trig     = r_trig;
    assign range_cnt   = r_range_cnt;
    assign range_valid = r_range_valid;
    assign echo_sig    = r_echo_sig;

endmodule

// File: doc/fsm_input_frontend.md
# fsm_input_frontend

Input front-end that turns raw board signals (four push-buttons, a light sensor, an HC-SR04-style ultrasonic ranger) into the clean single-cycle event pulses the pet state machine consumes: `feeding`, `healing`, `change_state`, `test`, `light_out`, `echo_sig`. It owns synchronisation, debouncing, edge detection and the ultrasonic trigger/echo measurement. Its pulse outputs connect directly to the state machine's like-named inputs.

## Interface
- `DEB_CYCLES`, 4: consecutive stable samples required before a debounced level changes (FPGA: 500000).
- `TRIG_CYCLES`, 10: `us_trig` high width (FPGA: 500).
- `PERIOD_CYCLES`, 200: minimum spacing between trigger starts (FPGA: 3000000).
- `NEAR_CYCLES`, 60: echo widths below this count as "near" (FPGA: ~1500000).
- `ECHO_TIMEOUT`, 150: maximum wait for echo rise, and maximum echo width counted (FPGA: 2000000).
- `CNT_W`, 22: width of the range counter.
- `clk  in  1`: system clock.
- `rst  in  1`: synchronous, active-high reset.
- `btn_feed_n, btn_heal_n, btn_mode_n, btn_test_n  in  1 each`: raw, asynchronous, active-low buttons.
- `ldr_dark  in  1`: raw light sensor; 1 = dark.
- `us_echo  in  1`: raw ultrasonic echo.
- `us_trig  out  1`: ultrasonic trigger.
- `feeding, healing, change_state, test  out  1 each`: one-cycle press pulses.
- `light_out  out  1`: one-cycle pulse on a light→dark transition.
- `echo_sig  out  1`: one-cycle pulse when an object first becomes near.
- `range_cnt  out  CNT_W`: last measured echo width in cycles.
- `range_valid  out  1`: one-cycle pulse when `range_cnt` updates.

## Operation
- All raw inputs pass through 2-FF synchronisers. Synchroniser reset values are the inactive levels: buttons 1, `ldr_dark` 0, `us_echo` 0.
- Debounce, per channel:
  - The counter resets whenever the synchronised sample equals the debounced level, or whenever the sample changes.
  - When the sample has differed from the debounced level for DEB_CYCLES consecutive cycles, the debounced level flips.
  - Button channels pulse only on the debounced press edge (1→0). Holding a button does not repeat the pulse. Release produces nothing.
  - `light_out` pulses only on the debounced 0→1 edge of `ldr_dark`.
- Ultrasonic FSM:
  - IDLE → TRIG on the cycle after reset release.
  - TRIG: `us_trig`=1 for exactly TRIG_CYCLES cycles, then → WAIT_RISE. The period counter starts at TRIG entry.
  - WAIT_RISE: on echo=1 → MEASURE with count 0. After ECHO_TIMEOUT cycles with no echo → DONE with count=ECHO_TIMEOUT.
  - MEASURE: increment count each cycle echo=1. On echo=0 → DONE. If count reaches ECHO_TIMEOUT it saturates → DONE.
  - DONE (1 cycle): `range_cnt` ← count and `range_valid`=1. `near` = (count < NEAR_CYCLES). `echo_sig`=1 iff `near` is true and the previous `near` was false. → HOLDOFF.
  - HOLDOFF: → TRIG when the period counter ≥ PERIOD_CYCLES and echo=0. While echo is still high, stay in HOLDOFF.
- All channels are independent. Pulses on several outputs in the same cycle are legal.

## Timing
- Reset values: every output is 0, FSM is IDLE, `near` is 0, all debounced levels are inactive, all counters are 0.
- Button/LDR latency: a pin change that stays stable produces its pulse exactly DEB_CYCLES+2 cycles after the first clock edge that samples the new level. The pulse is high for exactly 1 cycle.
- A glitch shorter than DEB_CYCLES cycles produces no pulse.
- `range_valid`, `range_cnt` and `echo_sig` change in the DONE cycle. `echo_sig` is never asserted outside DONE.
- Reset mid-operation:
  - `us_trig` is 0 from the cycle after the reset edge.
  - An in-flight measurement is discarded with no `range_valid`.
  - In-progress debounce counts are cleared.
- Counters are all unsigned and saturating. None of them wraps.

## Structure
- Package `fsm_input_pkg` holds:
  - the ultrasonic state encoding (IDLE, TRIG, WAIT_RISE, MEASURE, DONE, HOLDOFF);
  - the default timing constants for testbench and FPGA builds.
- Sub-module `debouncer`: synchroniser, counter, debounced level and edge pulse, with parameters DEB_CYCLES and polarity. It is instantiated 5 times (4 buttons, LDR).
- The ultrasonic FSM stays in the top level.

## Test plan
- `btn_feed_n` low for 20 cycles, then high → exactly one `feeding` pulse, 6 cycles after the first low sample; no pulse on release.
- `btn_test_n` low for 3 cycles (glitch) → no `test` pulse; then low for 10 cycles → one `test` pulse.
- Echo high for 30 cycles, starting 5 cycles after the trigger ends → `us_trig` 10 cycles wide; `range_cnt`=30, `range_valid` and `echo_sig` pulse. Repeat in the next period → `range_valid` only, no second `echo_sig`.
- Echo never rises → `range_cnt`=150 with `range_valid`; next trigger starts 200 cycles after the previous one. Echo held high for 200 cycles → count saturates at 150 and no new trigger until echo falls.
- `ldr_dark` 0→1 while `btn_heal_n` and `btn_mode_n` are pressed in the same cycle → `light_out`, `healing` and `change_state` pulse in the same cycle.
- `rst` asserted during MEASURE → all outputs 0 next cycle, no `range_valid`; after release a new trigger starts 2 cycles later.
